// File: rtl/corr_pkg.sv
// Shared defaults, types and FSM encoding for the correlation accumulator.
// The top exposes frame_clr only when CORR_ACC_FRAME_CLR_EN is defined.
package corr_pkg;

  localparam int unsigned CORR_PIXEL_SIZE    = 8;
  localparam int unsigned CORR_NUM_TEMPLATES = 4;
  localparam int unsigned CORR_WINDOW_LEN    = 64;
  localparam int unsigned CORR_ACC_EXT       = $clog2(CORR_WINDOW_LEN);

  typedef logic [CORR_PIXEL_SIZE-1:0]                pix_t;
  typedef logic [2*CORR_PIXEL_SIZE-1:0]              prod_t;
  typedef logic [CORR_PIXEL_SIZE+CORR_ACC_EXT-1:0]   sum_i_t;
  typedef logic [2*CORR_PIXEL_SIZE+CORR_ACC_EXT-1:0] sum_prod_t;

  // ACCUM: window still open; LAST: the next accepted sample closes the window
  typedef enum logic {
    ACCUM = 1'b0,
    LAST  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/corr_acc_lane.sv
// One clearable running sum plus the result register it unloads into when a
// window closes. The result register only changes on close.
module corr_acc_lane #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned SUM_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             acc_en,
  input  logic             close,
  input  logic [IN_W-1:0]  in_data,
  output logic [SUM_W-1:0] sum_o
);

  logic [SUM_W-1:0] acc_q, acc_d;
  logic [SUM_W-1:0] res_q, res_d;
  logic [SUM_W-1:0] add_c;

  assign add_c = acc_q + SUM_W'(in_data);

  always_comb begin
    acc_d = acc_q;
    res_d = res_q;
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      if (close) begin
        // closing sample goes straight into the result; the next window starts empty
        res_d = add_c;
        acc_d = '0;
      end else begin
        acc_d = add_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      res_q <= '0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end

  assign sum_o = res_q;

endmodule

// File: rtl/correlation_accumulator.sv
// Window accumulator for I, I^2 and T*I with a valid/ready result port.
// Optional frame_clr input is enabled by defining CORR_ACC_FRAME_CLR_EN.
module correlation_accumulator
  import corr_pkg::*;
#(
  parameter int unsigned PIXEL_SIZE    = CORR_PIXEL_SIZE,
  parameter int unsigned NUM_TEMPLATES = CORR_NUM_TEMPLATES,
  parameter int unsigned WINDOW_LEN    = CORR_WINDOW_LEN
) (
  input  logic                                                     CLK,
  input  logic                                                     RST_N,
`ifdef CORR_ACC_FRAME_CLR_EN
  input  logic                                                     frame_clr,
`endif
  input  logic                                                     in_valid,
  output logic                                                     in_ready,
  input  logic [PIXEL_SIZE-1:0]                                    I,
  input  logic [2*PIXEL_SIZE-1:0]                                  I_square,
  input  logic [NUM_TEMPLATES-1:0][2*PIXEL_SIZE-1:0]               T_x_I,
  output logic                                                     out_valid,
  input  logic                                                     out_ready,
  output logic [PIXEL_SIZE+$clog2(WINDOW_LEN)-1:0]                 sum_I,
  output logic [2*PIXEL_SIZE+$clog2(WINDOW_LEN)-1:0]               sum_I2,
  output logic [NUM_TEMPLATES-1:0][2*PIXEL_SIZE+$clog2(WINDOW_LEN)-1:0] sum_TI,
  output logic [15:0]                                              win_idx
);

  localparam int unsigned ACC_EXT  = $clog2(WINDOW_LEN);
  localparam int unsigned PROD_W   = 2 * PIXEL_SIZE;
  localparam int unsigned SUM_I_W  = PIXEL_SIZE + ACC_EXT;
  localparam int unsigned SUM_P_W  = PROD_W + ACC_EXT;
  localparam int unsigned CNT_W    = ACC_EXT;
  localparam int unsigned IDX_W    = 16;

  acc_state_e         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               out_valid_q, out_valid_d;
  logic [IDX_W-1:0]   win_idx_q, win_idx_d;

  logic               frame_clr_c;
  logic               in_ready_c;
  logic               accept_c;
  logic               close_c;

`ifdef CORR_ACC_FRAME_CLR_EN
  assign frame_clr_c = frame_clr;
`else
  assign frame_clr_c = 1'b0;
`endif

  // Only the closing sample can stall, and only while the previous result is unconsumed
  assign in_ready_c = !((state_q == LAST) && out_valid_q && !out_ready) && !frame_clr_c;
  assign accept_c   = in_valid && in_ready_c;
  assign close_c    = accept_c && (state_q == LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_clr_c) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM: if (accept_c && (count_q == CNT_W'(WINDOW_LEN - 2))) state_d = LAST;
        LAST:  if (accept_c) state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  always_comb begin
    count_d     = count_q;
    out_valid_d = out_valid_q;
    win_idx_d   = win_idx_q;
    if (frame_clr_c || close_c) begin
      count_d = '0;
    end else if (accept_c) begin
      count_d = count_q + CNT_W'(1);
    end
    // A reload in the handshake cycle keeps out_valid high
    if (close_c) begin
      out_valid_d = 1'b1;
      win_idx_d   = win_idx_q + IDX_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q     <= '0;
      out_valid_q <= 1'b0;
      win_idx_q   <= '0;
    end else begin
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      win_idx_q   <= win_idx_d;
    end
  end

  corr_acc_lane #(
    .IN_W  (PIXEL_SIZE),
    .SUM_W (SUM_I_W)
  ) u_lane_i (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (frame_clr_c),
    .acc_en  (accept_c),
    .close   (close_c),
    .in_data (I),
    .sum_o   (sum_I)
  );

  corr_acc_lane #(
    .IN_W  (PROD_W),
    .SUM_W (SUM_P_W)
  ) u_lane_i2 (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clr     (frame_clr_c),
    .acc_en  (accept_c),
    .close   (close_c),
    .in_data (I_square),
    .sum_o   (sum_I2)
  );

  for (genvar k = 0; k < NUM_TEMPLATES; k++) begin : g_ti
    corr_acc_lane #(
      .IN_W  (PROD_W),
      .SUM_W (SUM_P_W)
    ) u_lane_ti (
      .clk     (CLK),
      .rst_n   (RST_N),
      .clr     (frame_clr_c),
      .acc_en  (accept_c),
      .close   (close_c),
      .in_data (T_x_I[k]),
      .sum_o   (sum_TI[k])
    );
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign win_idx   = win_idx_q;

endmodule

// File: tb/tb_correlation_accumulator.sv
// Bench for correlation_accumulator (PIXEL_SIZE=8, NUM_TEMPLATES=2, WINDOW_LEN=4).
// Define CORR_ACC_FRAME_CLR_EN to also exercise frame_clr.
module tb_correlation_accumulator;

  localparam int unsigned PS  = 8;
  localparam int unsigned NT  = 2;
  localparam int unsigned WL  = 4;
  localparam int unsigned EXT = 2;

  logic                          CLK = 1'b0;
  logic                          RST_N;
  logic                          in_valid;
  logic                          in_ready;
  logic [PS-1:0]                 I;
  logic [2*PS-1:0]               I_square;
  logic [NT-1:0][2*PS-1:0]       T_x_I;
  logic                          out_valid;
  logic                          out_ready;
  logic [PS+EXT-1:0]             sum_I;
  logic [2*PS+EXT-1:0]           sum_I2;
  logic [NT-1:0][2*PS+EXT-1:0]   sum_TI;
  logic [15:0]                   win_idx;
`ifdef CORR_ACC_FRAME_CLR_EN
  logic                          frame_clr;
`endif

  correlation_accumulator #(
    .PIXEL_SIZE    (PS),
    .NUM_TEMPLATES (NT),
    .WINDOW_LEN    (WL)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
`ifdef CORR_ACC_FRAME_CLR_EN
    .frame_clr (frame_clr),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .I         (I),
    .I_square  (I_square),
    .T_x_I     (T_x_I),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_I     (sum_I),
    .sum_I2    (sum_I2),
    .sum_TI    (sum_TI),
    .win_idx   (win_idx)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] si;
    logic [31:0] si2;
    logic [31:0] st0;
    logic [31:0] st1;
    logic [15:0] win;
  } exp_t;

  typedef struct {
    logic [3:0][7:0] px;
    logic [7:0]      t0;
    logic [7:0]      t1;
    logic [31:0]     si;
    logic [31:0]     si2;
    logic [31:0]     st0;
    logic [31:0]     st1;
  } vec_t;

  vec_t        tbl [4];
  exp_t        sbq [$];
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] exp_win = 16'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: every output handshake pops and compares one expected window
  task automatic mon();
    exp_t e;
    if (RST_N && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got a result, expected none (win_idx=%0d)", win_idx);
      end else begin
        e = sbq.pop_front();
        chk("sb_sum_I",   64'(sum_I),     64'(e.si));
        chk("sb_sum_I2",  64'(sum_I2),    64'(e.si2));
        chk("sb_sum_TI0", 64'(sum_TI[0]), 64'(e.st0));
        chk("sb_sum_TI1", 64'(sum_TI[1]), 64'(e.st1));
        chk("sb_win_idx", 64'(win_idx),   64'(e.win));
      end
    end
  endtask

  task automatic push(input logic [31:0] si, input logic [31:0] si2,
                      input logic [31:0] st0, input logic [31:0] st1);
    exp_t e;
    exp_win = exp_win + 16'd1;
    e.si = si; e.si2 = si2; e.st0 = st0; e.st1 = st1; e.win = exp_win;
    sbq.push_back(e);
  endtask

  task automatic drive(input logic [7:0] i, input logic [7:0] t0, input logic [7:0] t1);
    I        = i;
    I_square = 16'(i) * 16'(i);
    T_x_I[0] = 16'(i) * 16'(t0);
    T_x_I[1] = 16'(i) * 16'(t1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK); mon();
      @(posedge CLK); #1;
    end
  endtask

  // Offer one sample and hold it until accepted, bounded
  task automatic send(input logic [7:0] i, input logic [7:0] t0, input logic [7:0] t1);
    logic took;
    took = 1'b0;
    drive(i, t0, t1);
    in_valid = 1'b1;
    for (int n = 0; n < 64 && !took; n++) begin
      @(negedge CLK); mon();
      took = in_ready;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    if (!took) chk("send_accept_timeout", 64'(took), 64'd1);
  endtask

  initial begin
    int pat [7];
    pat = '{1, 0, 0, 1, 0, 1, 1};

    tbl[0] = '{px: {8'd4, 8'd3, 8'd2, 8'd1},         t0: 8'd2,   t1: 8'd3,
               si: 32'd10,   si2: 32'd30,     st0: 32'd20,     st1: 32'd30};
    tbl[1] = '{px: {8'd255, 8'd255, 8'd255, 8'd255}, t0: 8'd255, t1: 8'd255,
               si: 32'd1020, si2: 32'd260100, st0: 32'd260100, st1: 32'd260100};
    tbl[2] = '{px: {8'd0, 8'd0, 8'd0, 8'd0},         t0: 8'd7,   t1: 8'd9,
               si: 32'd0,    si2: 32'd0,      st0: 32'd0,      st1: 32'd0};
    tbl[3] = '{px: {8'd40, 8'd30, 8'd20, 8'd10},     t0: 8'd1,   t1: 8'd0,
               si: 32'd100,  si2: 32'd3000,   st0: 32'd100,    st1: 32'd0};

    RST_N     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(8'd0, 8'd0, 8'd0);
`ifdef CORR_ACC_FRAME_CLR_EN
    frame_clr = 1'b0;
`endif
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum_I",     64'(sum_I),     64'd0);
    chk("rst_win_idx",   64'(win_idx),   64'd0);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Table windows, consumer always ready
    for (int r = 0; r < 4; r++) begin
      push(tbl[r].si, tbl[r].si2, tbl[r].st0, tbl[r].st1);
      for (int j = 0; j < 4; j++) begin
        send(tbl[r].px[j], tbl[r].t0, tbl[r].t1);
        if (r == 0 && j == 2) chk("lat_not_early", 64'(out_valid), 64'd0);
      end
      chk("lat_valid",   64'(out_valid), 64'd1);
      chk("lat_win_idx", 64'(win_idx),   64'(exp_win));
      idle(1);
    end

    // Gapped input stream
    push(32'd4, 32'd4, 32'd4, 32'd4);
    drive(8'd1, 8'd1, 8'd1);
    for (int k = 0; k < 7; k++) begin
      in_valid = pat[k][0];
      @(negedge CLK); mon();
      if (k == 6) chk("gap_no_early", 64'(out_valid), 64'd0);
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    chk("gap_valid", 64'(out_valid), 64'd1);
    idle(1);

    // Backpressure: closing sample of the second window stalls, then reloads on handshake
    out_ready = 1'b0;
    push(32'd100, 32'd3000, 32'd100, 32'd0);
    send(8'd10, 8'd1, 8'd0); send(8'd20, 8'd1, 8'd0);
    send(8'd30, 8'd1, 8'd0); send(8'd40, 8'd1, 8'd0);
    push(32'd8, 32'd16, 32'd24, 32'd40);
    send(8'd2, 8'd3, 8'd5); send(8'd2, 8'd3, 8'd5); send(8'd2, 8'd3, 8'd5);
    chk("bp_partial_accepted", 64'(out_valid), 64'd1);
    drive(8'd2, 8'd3, 8'd5);
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge CLK); mon();
      chk("bp_stall_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold_sum_I",     64'(sum_I),    64'd100);
      chk("bp_hold_sum_I2",    64'(sum_I2),   64'd3000);
      chk("bp_hold_win_idx",   64'(win_idx),  64'(exp_win - 16'd1));
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    @(negedge CLK); mon();
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("bp_reload_valid",   64'(out_valid), 64'd1);
    chk("bp_reload_win_idx", 64'(win_idx),   64'(exp_win));
    idle(1);

`ifdef CORR_ACC_FRAME_CLR_EN
    // Partial window cleared; the sample offered with frame_clr is dropped
    send(8'd5, 8'd1, 8'd1); send(8'd5, 8'd1, 8'd1);
    drive(8'd9, 8'd1, 8'd1);
    in_valid  = 1'b1;
    frame_clr = 1'b1;
    @(negedge CLK); mon();
    chk("fclr_in_ready", 64'(in_ready), 64'd0);
    @(posedge CLK); #1;
    frame_clr = 1'b0;
    in_valid  = 1'b0;
    push(32'd4, 32'd4, 32'd4, 32'd4);
    for (int j = 0; j < 4; j++) send(8'd1, 8'd1, 8'd1);
    idle(1);
`endif

    // Async reset with a pending result and a partial window
    out_ready = 1'b0;
    push(32'd4, 32'd4, 32'd0, 32'd0);
    for (int j = 0; j < 4; j++) send(8'd1, 8'd0, 8'd0);
    send(8'd3, 8'd3, 8'd3); send(8'd3, 8'd3, 8'd3);
    #2 RST_N = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_sum_I",     64'(sum_I),     64'd0);
    chk("arst_sum_I2",    64'(sum_I2),    64'd0);
    chk("arst_sum_TI0",   64'(sum_TI[0]), 64'd0);
    chk("arst_sum_TI1",   64'(sum_TI[1]), 64'd0);
    chk("arst_win_idx",   64'(win_idx),   64'd0);
    sbq.delete();
    exp_win = 16'd0;
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    push(32'd10, 32'd30, 32'd20, 32'd30);
    send(8'd1, 8'd2, 8'd3); send(8'd2, 8'd2, 8'd3);
    send(8'd3, 8'd2, 8'd3); send(8'd4, 8'd2, 8'd3);
    idle(3);
    chk("sb_drain", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
